arrow_scancode_tx: RTL

- Transmit-side counterpart of the arrow-key scancode decoder.
- Watches four level-sensitive arrow-key inputs and emits the PS/2 set-2 byte stream for each change:
  - make (press): E0, code
  - break (release): E0, F0, code
- Bytes leave on a valid/ready byte interface that feeds the serializer. One key event is in flight at a time.

---
 rtl/arrow_scancode_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/arrow_scancode_tx.sv
// Arrow-key scancode transmitter.
// Watches the four arrow-key levels and emits PS/2 set-2 make (E0,code) or
// break (E0,F0,code) byte streams on a valid/ready byte interface, one key
// event at a time. The byte output is named byte_o because "byte" is a
// reserved word in SystemVerilog.
module arrow_scancode_tx #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       left,
  input  logic       down,
  input  logic       right,
  input  logic       up,
  input  logic       ready,
  output logic [7:0] byte_o,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    BREAK  = 2'd2,
    CODE   = 2'd3
  } state_t;

  localparam logic [7:0] PREFIX_BYTE = 8'hE0;
  localparam logic [7:0] BREAK_BYTE  = 8'hF0;
  localparam logic [7:0] GAP_RELOAD  = 8'(GAP);

  state_t     state_q, state_d;
  logic [3:0] key_q;
  logic [3:0] reported_q, reported_d;
  logic [7:0] gap_q, gap_d;
  logic [1:0] sel_q, sel_d;
  logic       dir_q, dir_d;

  logic [3:0] pending;
  logic [1:0] pick;
  logic [7:0] sel_code;

  // Bit order {left,down,right,up}: bit 3 is the highest-priority key.
  assign pending = key_q ^ reported_q;

  // Pick the highest-priority key whose level differs from what was last sent.
  always_comb begin
    pick = 2'd0;
    if (pending[3]) begin
      pick = 2'd3;
    end else if (pending[2]) begin
      pick = 2'd2;
    end else if (pending[1]) begin
      pick = 2'd1;
    end else begin
      pick = 2'd0;
    end
  end

  // Scancode of the key frozen for the sequence in flight.
  always_comb begin
    case (sel_q)
      2'd3:    sel_code = 8'h6B;
      2'd2:    sel_code = 8'h72;
      2'd1:    sel_code = 8'h74;
      default: sel_code = 8'h75;
    endcase
  end

  // Sample the key levels every edge; reset treats every key as released.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      key_q <= 4'b0000;
    end else begin
      key_q <= {left, down, right, up};
    end
  end

  // State, reported-key mirror, gap counter and the frozen key/direction.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      reported_q <= 4'b0000;
      gap_q      <= 8'd0;
      sel_q      <= 2'd0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reported_q <= reported_d;
      gap_q      <= gap_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
    end
  end

  // Next-state and output logic; byte/valid depend only on state so they stay
  // stable while the downstream stalls.
  always_comb begin
    state_d    = state_q;
    reported_d = reported_q;
    gap_d      = gap_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    valid      = 1'b0;
    byte_o     = 8'h00;

    case (state_q)
      IDLE: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (pending != 4'b0000) begin
          sel_d   = pick;
          dir_d   = key_q[pick];
          state_d = PREFIX;
        end
      end
      PREFIX: begin
        valid  = 1'b1;
        byte_o = PREFIX_BYTE;
        if (ready) begin
          state_d = dir_q ? CODE : BREAK;
        end
      end
      BREAK: begin
        valid  = 1'b1;
        byte_o = BREAK_BYTE;
        if (ready) begin
          state_d = CODE;
        end
      end
      CODE: begin
        valid  = 1'b1;
        byte_o = sel_code;
        if (ready) begin
          reported_d[sel_q] = dir_q;
          gap_d             = GAP_RELOAD;
          state_d           = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
